// File: rtl/c1541_pkg.sv
// Shared types and helpers for the multi-drive 1541 head/track logic.
package c1541_pkg;

  typedef enum logic {IDLE, REQ} arb_state_e;

  // Returns {fwd, back}; the stepper phase order 0-2-1-3 moves the head up one half-track.
  function automatic logic [1:0] step_dir(input logic [1:0] prev, input logic [1:0] cur);
    case ({prev, cur})
      4'b0010, 4'b1001, 4'b0111, 4'b1100: step_dir = 2'b10;
      4'b0011, 4'b1000, 4'b0110, 4'b1101: step_dir = 2'b01;
      default:                            step_dir = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/c1541_head_chan.sv
// One drive mechanism: stepper/half-track counter, dirty-track tracking,
// disk-change timer and write-protect sense.
module c1541_head_chan
  import c1541_pkg::*;
#(
  parameter int MAX_HALFTRACK   = 80,
  parameter int RESET_HALFTRACK = 36,
  parameter int TRACK_W         = 6,
  parameter int CHG_W           = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce,
  input  logic               mtr,
  input  logic [1:0]         stp,
  input  logic               act,
  input  logic               buff_we,
  input  logic               disk_change,
  input  logic               disk_readonly,
  input  logic               clr,
  input  logic               granted,
  output logic [TRACK_W-1:0] track,
  output logic               tr00_n,
  output logic               wps_n,
  output logic               pending,
  output logic [TRACK_W-1:0] pend_track
);

  localparam int HT_W = TRACK_W + 1;

  logic [HT_W-1:0]  halftrack;
  logic [1:0]       stp_r;
  logic [1:0]       dir;
  logic             act_r;
  logic             dc_r;
  logic             modified;
  logic             rearm;
  logic             readonly;
  logic [CHG_W-1:0] chg;
  logic             stepped;
  logic             trigger;
  logic             set_pend;

  always_comb begin
    dir      = step_dir(stp_r, stp);
    stepped  = ce & mtr & (|dir);
    trigger  = stepped | (ce & act_r & ~act);
    set_pend = trigger & ~disk_change & (modified | buff_we);
  end

  assign tr00_n = |track;
  assign wps_n  = ~readonly ^ chg[CHG_W-2];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      halftrack  <= HT_W'(RESET_HALFTRACK);
      track      <= TRACK_W'(RESET_HALFTRACK >> 1);
      stp_r      <= '0;
      act_r      <= 1'b0;
      dc_r       <= 1'b0;
      modified   <= 1'b0;
      pending    <= 1'b0;
      rearm      <= 1'b0;
      pend_track <= '0;
      readonly   <= 1'b0;
      chg        <= '0;
    end else begin
      dc_r <= disk_change;
      if (disk_change && !dc_r) begin
        chg      <= '1;
        readonly <= disk_readonly;
      end else if (ce && chg != '0) begin
        chg <= chg - 1'b1;
      end

      // A trigger while this drive is being granted must survive the ack that clears pending.
      if (clr) begin
        pending <= rearm | set_pend;
        rearm   <= 1'b0;
      end else if (set_pend) begin
        pending <= 1'b1;
        rearm   <= rearm | granted;
      end
      if (set_pend)
        pend_track <= track;
      if (disk_change) begin
        rearm <= 1'b0;
        if (!granted)
          pending <= 1'b0;
      end

      if (disk_change)
        modified <= 1'b0;
      else if (ce) begin
        if (trigger)
          modified <= 1'b0;
        else if (buff_we)
          modified <= 1'b1;
      end

      if (ce) begin
        stp_r <= stp;
        act_r <= act;
        track <= halftrack[TRACK_W:1];
        if (mtr && dir[1] && halftrack != HT_W'(MAX_HALFTRACK))
          halftrack <= halftrack + 1'b1;
        else if (mtr && dir[0] && halftrack != HT_W'(1))
          halftrack <= halftrack - 1'b1;
      end
    end
  end

endmodule

// File: rtl/c1541_multi_head.sv
// Head/track state for NUM_DRIVES drives plus a round-robin arbiter that
// serialises dirty-track flushes to the shared SD track buffer.
module c1541_multi_head
  import c1541_pkg::*;
#(
  parameter int  NUM_DRIVES      = 2,
  parameter int  MAX_HALFTRACK   = 80,
  parameter int  RESET_HALFTRACK = 36,
  parameter int  TRACK_W         = 6,
  parameter int  CHG_W           = 24,
  localparam int DRV_W           = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ce,
  input  logic [NUM_DRIVES-1:0]         mtr,
  input  logic [2*NUM_DRIVES-1:0]       stp,
  input  logic [NUM_DRIVES-1:0]         act,
  input  logic [NUM_DRIVES-1:0]         buff_we,
  input  logic [NUM_DRIVES-1:0]         disk_change,
  input  logic [NUM_DRIVES-1:0]         disk_readonly,
  output logic [TRACK_W*NUM_DRIVES-1:0] track,
  output logic [NUM_DRIVES-1:0]         tr00_n,
  output logic [NUM_DRIVES-1:0]         wps_n,
  output logic                          save_req,
  output logic [DRV_W-1:0]              save_drive,
  output logic [TRACK_W-1:0]            save_track,
  input  logic                          save_ack
);

  arb_state_e         state;
  logic [DRV_W-1:0]   ptr;
  logic [DRV_W-1:0]   sel;
  logic               found;
  int unsigned        idx;
  logic [NUM_DRIVES-1:0] pending;
  logic [NUM_DRIVES-1:0] granted;
  logic [NUM_DRIVES-1:0] clr;
  logic [TRACK_W-1:0] pend_track [NUM_DRIVES];

  for (genvar d = 0; d < NUM_DRIVES; d++) begin : g_chan
    c1541_head_chan #(
      .MAX_HALFTRACK  (MAX_HALFTRACK),
      .RESET_HALFTRACK(RESET_HALFTRACK),
      .TRACK_W        (TRACK_W),
      .CHG_W          (CHG_W)
    ) u_chan (
      .clk          (clk),
      .reset_n      (reset_n),
      .ce           (ce),
      .mtr          (mtr[d]),
      .stp          (stp[2*d +: 2]),
      .act          (act[d]),
      .buff_we      (buff_we[d]),
      .disk_change  (disk_change[d]),
      .disk_readonly(disk_readonly[d]),
      .clr          (clr[d]),
      .granted      (granted[d]),
      .track        (track[TRACK_W*d +: TRACK_W]),
      .tr00_n       (tr00_n[d]),
      .wps_n        (wps_n[d]),
      .pending      (pending[d]),
      .pend_track   (pend_track[d])
    );
  end

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_DRIVES; i++) begin
      idx = (32'(ptr) + i) % 32'(NUM_DRIVES);
      if (!found && pending[idx]) begin
        found = 1'b1;
        sel   = DRV_W'(idx);
      end
    end
    for (int unsigned d = 0; d < NUM_DRIVES; d++) begin
      granted[d] = (state == REQ) && (32'(save_drive) == d);
      clr[d]     = granted[d] & save_ack;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      save_req   <= 1'b0;
      save_drive <= '0;
      save_track <= '0;
      ptr        <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          state      <= REQ;
          save_req   <= 1'b1;
          save_drive <= sel;
          save_track <= pend_track[sel];
        end
        REQ: if (save_ack) begin
          state    <= IDLE;
          save_req <= 1'b0;
          ptr      <= (32'(save_drive) == 32'(NUM_DRIVES - 1)) ? '0 : save_drive + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
